uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8-bit asynchronous serial receiver (8 data bits, LSB first,
// optional even parity, 1 stop bit) with a one-entry holding register.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in bit/s
//   PARITY_EN  1 = an even-parity bit follows the data bits
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rx_ready    consumer acknowledge of the held byte
//   rx_data     last received byte (held until the next rx_done)
//   rx_done     one-cycle pulse at the end of every frame
//   rx_valid    a byte is held and has not been acknowledged
//   frame_err   stop bit sampled low (valid with rx_done, held)
//   parity_err  parity mismatch (valid with rx_done, held; 0 without parity)
//   overrun     one-cycle pulse when a new byte replaces an unacknowledged one
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int PARITY_EN = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);

   localparam int BIT_CNT = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CNT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q, sync_d;     // [1] is the synchronized line rx_s
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;       // parity result, published at STOP
   logic             brk_q, brk_d;       // line must return high before a new start
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_done_q, rx_done_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             parity_err_q, parity_err_d;
   logic             overrun_q, overrun_d;
   logic             rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      // NOTE: every _d takes its held value first so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      sync_d       = {sync_q[0], rx};
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      par_d        = par_q;
      brk_d        = brk_q;
      rx_data_d    = rx_data_q;
      rx_done_d    = 1'b0;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (brk_q) begin
               if (rx_s) brk_d = 1'b0;
            end else if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               // A line back high at mid start bit was a glitch: drop silently.
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               par_d   = (^shift_q) ^ rx_s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d        = '0;
               rx_data_d    = shift_q;
               frame_err_d  = ~rx_s;
               parity_err_d = (PARITY_EN != 0) && par_q;
               rx_done_d    = 1'b1;
               overrun_d    = rx_valid_q && !rx_ready;
               brk_d        = ~rx_s;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new byte always wins over an acknowledge in the same cycle.
      if (rx_done_d)     rx_valid_d = 1'b1;
      else if (rx_ready) rx_valid_d = 1'b0;
      else               rx_valid_d = rx_valid_q;
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         brk_q        <= 1'b0;
         rx_data_q    <= '0;
         rx_done_q    <= 1'b0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         brk_q        <= brk_d;
         rx_data_q    <= rx_data_d;
         rx_done_q    <= rx_done_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_done    = rx_done_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx. Two instances with a scaled clock
// ratio (16 clocks per bit, half bit = 8): u_rx without parity, u_rxp with
// even parity. Expected frame latency = 2 + 8 + 9*16 + 1 = 155 cycles.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int BIT      = CLK_FREQ / BAUD;   // 16
   localparam int LAT      = 2 + BIT / 2 + 9 * BIT + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx0 = 1'b1;
   logic       rx1 = 1'b1;
   logic       rx_ready = 1'b0;

   logic [7:0] rx_data0, rx_data1;
   logic       rx_done0, rx_done1, rx_valid0, rx_valid1;
   logic       frame_err0, frame_err1, parity_err0, parity_err1;
   logic       overrun0, overrun1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cyc0 = 0;
   int dcnt0 = 0;
   int dcnt1 = 0;
   int ov_cycles0 = 0;
   logic ov_at_done0 = 1'b0;
   int base;

   always #5 clk = ~clk;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(0)) u_rx (
      .clk(clk), .rst(rst), .rx(rx0), .rx_ready(rx_ready),
      .rx_data(rx_data0), .rx_done(rx_done0), .rx_valid(rx_valid0),
      .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0)
   );

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1)) u_rxp (
      .clk(clk), .rst(rst), .rx(rx1), .rx_ready(rx_ready),
      .rx_data(rx_data1), .rx_done(rx_done1), .rx_valid(rx_valid1),
      .frame_err(frame_err1), .parity_err(parity_err1), .overrun(overrun1)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done0) begin
         dcnt0++;
         done_cyc0 = cyc;
         ov_at_done0 = overrun0;
      end
      if (overrun0) ov_cycles0++;
      if (rx_done1) dcnt1++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic drive_bit(input bit sel, input bit v);
      @(negedge clk);
      if (sel) rx1 = v; else rx0 = v;
      repeat (BIT - 1) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit stop_b,
                             input bit use_par, input bit par_b);
      @(negedge clk);
      if (sel) rx1 = 1'b0; else rx0 = 1'b0;
      start_cyc = cyc;
      repeat (BIT - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
      if (use_par) drive_bit(sel, par_b);
      drive_bit(sel, stop_b);
   endtask

   task automatic ack();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_out0", {19'd0, rx_data0, rx_done0, rx_valid0, frame_err0, parity_err0, overrun0}, 32'd0);
      check("reset_out1", {19'd0, rx_data1, rx_done1, rx_valid1, frame_err1, parity_err1, overrun1}, 32'd0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Basic frame 0x41 with latency.
      send_frame(0, 8'h41, 1, 0, 0);
      repeat (4) @(negedge clk);
      check("f41_done_cnt", dcnt0, 1);
      check("f41_data", rx_data0, 8'h41);
      check("f41_frame_err", frame_err0, 0);
      check("f41_parity_err", parity_err0, 0);
      check("f41_valid", rx_valid0, 1);
      check("f41_latency_ok", ((done_cyc0 - start_cyc) >= LAT - 1) && ((done_cyc0 - start_cyc) <= LAT + 1), 1);
      ack();
      @(negedge clk);
      check("f41_ack_valid", rx_valid0, 0);
      check("f41_data_held", rx_data0, 8'h41);

      // Short low glitch is ignored.
      base = dcnt0;
      @(negedge clk); rx0 = 1'b0;
      repeat (4) @(negedge clk); rx0 = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_no_done", dcnt0, base);
      check("glitch_idle", 32'(u_rx.state_q), 0);
      check("glitch_valid", rx_valid0, 0);
      send_frame(0, 8'h55, 1, 0, 0);
      repeat (4) @(negedge clk);
      check("f55_done_cnt", dcnt0, base + 1);
      check("f55_data", rx_data0, 8'h55);
      ack();

      // Framing error followed by a break.
      base = dcnt0;
      send_frame(0, 8'hA5, 0, 0, 0);
      repeat (2 * BIT) @(negedge clk);
      check("brk_done_cnt", dcnt0, base + 1);
      check("brk_frame_err", frame_err0, 1);
      check("brk_data", rx_data0, 8'hA5);
      check("brk_idle_while_low", 32'(u_rx.state_q), 0);
      rx0 = 1'b1;
      repeat (200) @(negedge clk);
      check("brk_no_spurious", dcnt0, base + 1);
      check("brk_frame_err_held", frame_err0, 1);
      ack();

      // Overrun: two frames back to back without acknowledge.
      base = dcnt0;
      ov_cycles0 = 0;
      send_frame(0, 8'h12, 1, 0, 0);
      check("ov1_overrun", ov_at_done0, 0);
      check("ov1_frame_err", frame_err0, 0);
      send_frame(0, 8'h34, 1, 0, 0);
      repeat (4) @(negedge clk);
      check("ov2_done_cnt", dcnt0, base + 2);
      check("ov2_overrun", ov_at_done0, 1);
      check("ov2_pulse_len", ov_cycles0, 1);
      check("ov2_data", rx_data0, 8'h34);
      check("ov2_valid", rx_valid0, 1);
      ack();
      @(negedge clk);
      check("ov_ack_valid", rx_valid0, 0);

      // Parity on the parity-enabled instance.
      send_frame(1, 8'h03, 1, 1, 1);
      repeat (4) @(negedge clk);
      check("par1_done_cnt", dcnt1, 1);
      check("par1_data", rx_data1, 8'h03);
      check("par1_err", parity_err1, 1);
      check("par1_frame_err", frame_err1, 0);
      send_frame(1, 8'h03, 1, 1, 0);
      repeat (4) @(negedge clk);
      check("par0_done_cnt", dcnt1, 2);
      check("par0_err", parity_err1, 0);
      check("nopar_err_zero", parity_err0, 0);

      // Reset during data bit 4 aborts the frame.
      base = dcnt0;
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b0);
      @(negedge clk); rx0 = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_out0", {19'd0, rx_data0, rx_done0, rx_valid0, frame_err0, parity_err0, overrun0}, 32'd0);
      check("rst_mid_out1", {19'd0, rx_data1, rx_done1, rx_valid1, frame_err1, parity_err1, overrun1}, 32'd0);
      repeat (8) @(negedge clk);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_mid_no_done", dcnt0, base);
      check("rst_mid_idle", 32'(u_rx.state_q), 0);
      send_frame(0, 8'h41, 1, 0, 0);
      repeat (4) @(negedge clk);
      check("rst_after_done_cnt", dcnt0, base + 1);
      check("rst_after_data", rx_data0, 8'h41);
      check("rst_after_frame_err", frame_err0, 0);
      check("rst_after_valid", rx_valid0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
